// File: rtl/id_operand_stage.sv
// Decode-to-execute operand stage: regfile read addressing, EX/MEM/WB operand bypass,
// load-use stall and the ID/EX pipeline register. Define OPSTAGE_WB_BYPASS_EN to add the WB bypass.
module id_operand_stage #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_rs,
    input  logic [AW-1:0] in_rt,
    input  logic [AW-1:0] in_rd,
    input  logic          in_wen,
    input  logic          in_is_load,
    input  logic [DW-1:0] in_imm,
    input  logic [CW-1:0] in_ctrl,
    output logic [AW-1:0] raddr1,
    output logic [AW-1:0] raddr2,
    input  logic [DW-1:0] rdata1,
    input  logic [DW-1:0] rdata2,
    input  logic          ex_valid,
    input  logic          ex_wen,
    input  logic          ex_is_load,
    input  logic [AW-1:0] ex_addr,
    input  logic [DW-1:0] ex_data,
    input  logic          mem_valid,
    input  logic          mem_wen,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_waddr,
    input  logic [DW-1:0] wb_wdata,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_op1,
    output logic [DW-1:0] out_op2,
    output logic [AW-1:0] out_rd,
    output logic          out_wen,
    output logic          out_is_load,
    output logic [DW-1:0] out_imm,
    output logic [CW-1:0] out_ctrl,
    output logic [15:0]   stall_count
);

    logic          hazard;
    logic          capture;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;

    assign raddr1 = in_rs;
    assign raddr2 = in_rt;

    // A load in EX has no data yet, so it never forwards; it stalls instead.
    function automatic logic [DW-1:0] resolve(input logic [AW-1:0] src, input logic [DW-1:0] rf);
        logic [DW-1:0] val;
        val = rf;
        if (src == '0)
            val = '0;
        else if (ex_valid && ex_wen && !ex_is_load && ex_addr == src)
            val = ex_data;
        else if (mem_valid && mem_wen && mem_addr == src)
            val = mem_data;
`ifdef OPSTAGE_WB_BYPASS_EN
        else if (wb_we && wb_waddr == src)
            val = wb_wdata;
`endif
        return val;
    endfunction

`ifndef OPSTAGE_WB_BYPASS_EN
    // Regfile is write-first here, so the WB port is intentionally not observed.
    logic wb_unused;
    assign wb_unused = ^{wb_we, wb_waddr, wb_wdata};
`endif

    always_comb begin
        op1 = resolve(in_rs, rdata1);
        op2 = resolve(in_rt, rdata2);
    end

    assign hazard = in_valid && ex_valid && ex_wen && ex_is_load && (ex_addr != '0)
                    && (ex_addr == in_rs || ex_addr == in_rt);
    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign capture  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_rd      <= '0;
            out_wen     <= 1'b0;
            out_is_load <= 1'b0;
            out_imm     <= '0;
            out_ctrl    <= '0;
            stall_count <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (capture) begin
                out_valid   <= 1'b1;
                out_op1     <= op1;
                out_op2     <= op2;
                out_rd      <= in_rd;
                out_wen     <= in_wen;
                out_is_load <= in_is_load;
                out_imm     <= in_imm;
                out_ctrl    <= in_ctrl;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (hazard && !flush && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios plus randomized traffic
// checked against a behavioural model of the operand stage.
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic        in_wen, in_is_load;
    logic [31:0] in_imm;
    logic [15:0] in_ctrl;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        ex_valid, ex_wen, ex_is_load;
    logic [4:0]  ex_addr;
    logic [31:0] ex_data;
    logic        mem_valid, mem_wen;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_op1, out_op2, out_imm;
    logic [4:0]  out_rd;
    logic        out_wen, out_is_load;
    logic [15:0] out_ctrl;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model of the ID/EX register contents
    logic        m_valid, m_wen, m_ld;
    logic [31:0] m_op1, m_op2, m_imm;
    logic [4:0]  m_rd;
    logic [15:0] m_ctrl, m_cnt;

    always #5 clk = ~clk;

    id_operand_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_wen(in_wen),
        .in_is_load(in_is_load), .in_imm(in_imm), .in_ctrl(in_ctrl),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
        .ex_addr(ex_addr), .ex_data(ex_data), .mem_valid(mem_valid),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_data(mem_data),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1),
        .out_op2(out_op2), .out_rd(out_rd), .out_wen(out_wen),
        .out_is_load(out_is_load), .out_imm(out_imm), .out_ctrl(out_ctrl),
        .stall_count(stall_count)
    );

    function automatic logic [31:0] ref_operand(input logic [4:0] s, input logic [31:0] rf);
        if (s == 0) return 32'd0;
        if (ex_valid && ex_wen && !ex_is_load && ex_addr == s) return ex_data;
        if (mem_valid && mem_wen && mem_addr == s) return mem_data;
`ifdef OPSTAGE_WB_BYPASS_EN
        if (wb_we && wb_waddr == s) return wb_wdata;
`endif
        return rf;
    endfunction

    function automatic logic ref_hazard();
        return in_valid && ex_valid && ex_wen && ex_is_load && ex_addr != 0
               && (ex_addr == in_rs || ex_addr == in_rt);
    endfunction

    function automatic logic ref_ready();
        return (!m_valid || out_ready) && !ref_hazard() && !flush;
    endfunction

    // Advance one clock, updating the model from the inputs present at the edge.
    task automatic advance();
        logic        hz, rdy;
        logic [31:0] r1, r2;
        hz  = ref_hazard();
        rdy = ref_ready();
        r1  = ref_operand(in_rs, rdata1);
        r2  = ref_operand(in_rt, rdata2);
        @(posedge clk);
        if (!rst) begin
            m_valid = 0; m_op1 = 0; m_op2 = 0; m_rd = 0; m_wen = 0;
            m_ld = 0; m_imm = 0; m_ctrl = 0; m_cnt = 0;
        end else begin
            if (flush) m_valid = 0;
            else if (in_valid && rdy) begin
                m_valid = 1; m_op1 = r1; m_op2 = r2; m_rd = in_rd; m_wen = in_wen;
                m_ld = in_is_load; m_imm = in_imm; m_ctrl = in_ctrl;
            end else if (out_ready) m_valid = 0;
            if (hz && !flush && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        #1;
    endtask

    task automatic idle();
        rst = 1; in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_wen = 0;
        in_is_load = 0; in_imm = 0; in_ctrl = 0; rdata1 = 0; rdata2 = 0;
        ex_valid = 0; ex_wen = 0; ex_is_load = 0; ex_addr = 0; ex_data = 0;
        mem_valid = 0; mem_wen = 0; mem_addr = 0; mem_data = 0;
        wb_we = 0; wb_waddr = 0; wb_wdata = 0; flush = 0; out_ready = 1;
    endtask

    task automatic test_reset();
        idle();
        rst = 0; in_valid = 1; in_rs = 4; in_rt = 6; rdata1 = 32'h55; rdata2 = 32'h66;
        advance(); advance();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_cmp++; if ({out_op1, out_op2} !== 64'd0) begin n_bad++; $display("FAIL reset_ops got=%h/%h exp=0", out_op1, out_op2); end
        rst = 1; in_valid = 0;
        advance();
        n_cmp++; if (out_valid !== 1'b0 || stall_count !== 16'd0) begin
            n_bad++; $display("FAIL reset_release got v=%b cnt=%0d exp v=0 cnt=0", out_valid, stall_count); end
    endtask

    task automatic test_wb_bypass();
        logic [31:0] exp;
        idle();
        in_valid = 1; in_rs = 1; in_rt = 1; rdata1 = 0; rdata2 = 0;
        wb_we = 1; wb_waddr = 1; wb_wdata = 10;
`ifdef OPSTAGE_WB_BYPASS_EN
        exp = 10;
`else
        exp = 0;
`endif
        #1;
        n_cmp++; if (raddr1 !== 5'd1 || raddr2 !== 5'd1) begin
            n_bad++; $display("FAIL raddr got=%0d/%0d exp=1/1", raddr1, raddr2); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL wb_ready got=%b exp=1", in_ready); end
        advance();
        n_cmp++; if (out_valid !== 1'b1 || out_op1 !== exp || out_op2 !== exp) begin
            n_bad++; $display("FAIL wb_bypass got v=%b %h/%h exp %h", out_valid, out_op1, out_op2, exp); end
    endtask

    task automatic test_priority();
        logic [31:0] exp [4];
`ifdef OPSTAGE_WB_BYPASS_EN
        exp = '{32'h11, 32'h22, 32'h33, 32'h0};
`else
        exp = '{32'h11, 32'h22, 32'h44, 32'h0};
`endif
        idle();
        in_valid = 1; in_rs = 3; rdata1 = 32'h44;
        ex_valid = 1; ex_wen = 1; ex_addr = 3; ex_data = 32'h11;
        mem_valid = 1; mem_wen = 1; mem_addr = 3; mem_data = 32'h22;
        wb_we = 1; wb_waddr = 3; wb_wdata = 32'h33;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) ex_valid = 0;
            if (k == 2) mem_valid = 0;
            if (k == 3) begin
                in_rs = 0; ex_valid = 1; mem_valid = 1;
                ex_addr = 0; mem_addr = 0; wb_waddr = 0;
            end
            advance();
            n_cmp++; if (out_op1 !== exp[k]) begin
                n_bad++; $display("FAIL priority_%0d got=%h exp=%h", k, out_op1, exp[k]); end
        end
    endtask

    task automatic test_load_use();
        idle();
        in_valid = 1; in_rs = 0; in_rt = 5; rdata2 = 32'h9999;
        ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_addr = 5; ex_data = 32'h7777;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL loaduse_ready got=%b exp=0", in_ready); end
        advance();
        n_cmp++; if (out_valid !== 1'b0 || stall_count !== 16'd1) begin
            n_bad++; $display("FAIL loaduse_bubble got v=%b cnt=%0d exp v=0 cnt=1", out_valid, stall_count); end
        ex_valid = 0; mem_valid = 1; mem_wen = 1; mem_addr = 5; mem_data = 32'hABCD;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL loaduse_resume got=%b exp=1", in_ready); end
        advance();
        n_cmp++; if (out_valid !== 1'b1 || out_op2 !== 32'hABCD || stall_count !== 16'd1) begin
            n_bad++; $display("FAIL loaduse_fwd got v=%b op2=%h cnt=%0d exp 1/abcd/1", out_valid, out_op2, stall_count); end
    endtask

    task automatic test_backpressure();
        idle();
        in_valid = 1; in_rs = 8; in_rt = 9; in_rd = 12; rdata1 = 32'hA1; rdata2 = 32'hA2; in_imm = 32'h100;
        advance();
        out_ready = 0; in_rs = 10; in_rt = 11; in_rd = 13; rdata1 = 32'hB1; rdata2 = 32'hB2; in_imm = 32'h200;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_%0d got=%b exp=0", k, in_ready); end
            advance();
            n_cmp++; if ({out_valid, out_op1, out_op2, out_rd, out_imm} !== {1'b1, 32'hA1, 32'hA2, 5'd12, 32'h100}) begin
                n_bad++; $display("FAIL bp_hold_%0d got v=%b %h %h rd=%0d", k, out_valid, out_op1, out_op2, out_rd); end
        end
        out_ready = 1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got=%b exp=1", in_ready); end
        advance();
        n_cmp++; if ({out_valid, out_op1, out_rd, out_imm} !== {1'b1, 32'hB1, 5'd13, 32'h200}) begin
            n_bad++; $display("FAIL bp_next got v=%b op1=%h rd=%0d", out_valid, out_op1, out_rd); end
    endtask

    task automatic test_flush();
        logic [15:0] cnt0;
        idle();
        in_valid = 1; in_rs = 2; rdata1 = 32'hC1;
        advance();
        flush = 1; out_ready = 0; rdata1 = 32'hC2;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
        advance();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        flush = 0;
        advance();
        n_cmp++; if (out_valid !== 1'b1 || out_op1 !== 32'hC2) begin
            n_bad++; $display("FAIL flush_retry got v=%b op1=%h exp 1/c2", out_valid, out_op1); end
        cnt0 = m_cnt;
        out_ready = 1; flush = 1; ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_addr = 2;
        advance();
        n_cmp++; if (stall_count !== cnt0) begin
            n_bad++; $display("FAIL flush_nocount got=%0d exp=%0d", stall_count, cnt0); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) >= 2);
            in_valid = ($urandom_range(0, 9) < 8);
            in_rs = 5'($urandom_range(0, 3)); in_rt = 5'($urandom_range(0, 3));
            in_rd = 5'($urandom); in_wen = 1'($urandom); in_is_load = 1'($urandom);
            in_imm = $urandom; in_ctrl = 16'($urandom);
            rdata1 = $urandom; rdata2 = $urandom;
            ex_valid = 1'($urandom); ex_wen = 1'($urandom); ex_is_load = ($urandom_range(0, 9) < 3);
            ex_addr = 5'($urandom_range(0, 3)); ex_data = $urandom;
            mem_valid = 1'($urandom); mem_wen = 1'($urandom);
            mem_addr = 5'($urandom_range(0, 3)); mem_data = $urandom;
            wb_we = 1'($urandom); wb_waddr = 5'($urandom_range(0, 3)); wb_wdata = $urandom;
            flush = ($urandom_range(0, 99) < 5); out_ready = ($urandom_range(0, 9) < 7);
            #1;
            n_cmp++; if (in_ready !== ref_ready()) begin
                n_bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, in_ready, ref_ready()); end
            advance();
            n_cmp++;
            if ({out_valid, out_op1, out_op2, out_rd, out_wen, out_is_load, out_imm, out_ctrl, stall_count}
                !== {m_valid, m_op1, m_op2, m_rd, m_wen, m_ld, m_imm, m_ctrl, m_cnt}) begin
                n_bad++;
                $display("FAIL rnd_out cyc=%0d got v=%b %h %h rd=%0d cnt=%0d exp v=%b %h %h rd=%0d cnt=%0d",
                         i, out_valid, out_op1, out_op2, out_rd, stall_count, m_valid, m_op1, m_op2, m_rd, m_cnt);
            end
        end
    endtask

    task automatic test_saturation();
        idle();
        in_valid = 1; in_rs = 7; ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_addr = 7;
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFE; i++) advance();
        n_cmp++; if (stall_count !== 16'hFFFE) begin
            n_bad++; $display("FAIL sat_pre got=%h exp=fffe", stall_count); end
        advance();
        n_cmp++; if (stall_count !== 16'hFFFF) begin
            n_bad++; $display("FAIL sat_reach got=%h exp=ffff", stall_count); end
        advance(); advance();
        n_cmp++; if (stall_count !== 16'hFFFF || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL sat_hold got=%h ready=%b exp=ffff/0", stall_count, in_ready); end
    endtask

    initial begin
        idle();
        rst = 0;
        test_reset();
        test_wb_bypass();
        test_priority();
        test_load_use();
        test_backpressure();
        test_flush();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode-to-execute operand stage; sits directly downstream of the CPU register file.
- Drives regfile read addresses from the decoded instruction and resolves both operands, bypassing in-flight EX, MEM and WB results.
- Detects load-use hazards and stalls the decode stage.
- Registers the resolved operands into the ID/EX pipeline register, with valid/ready handshake and flush.

Parameters:
- DW, 32, data/operand width
- AW, 5, register address width (32 registers, r0 hardwired zero)
- CW, 16, opaque control bundle width passed through to EX

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_rs  in  AW  source register 1
- in_rt  in  AW  source register 2
- in_rd  in  AW  destination register
- in_wen  in  1  instruction writes in_rd
- in_is_load  in  1  instruction is a load
- in_imm  in  DW  immediate
- in_ctrl  in  CW  control bundle
- raddr1  out  AW  regfile read address 1
- raddr2  out  AW  regfile read address 2
- rdata1  in  DW  regfile read data 1
- rdata2  in  DW  regfile read data 2
- ex_valid  in  1  EX-stage instruction valid
- ex_wen  in  1  EX instruction writes a register
- ex_is_load  in  1  EX instruction is a load (data not yet available)
- ex_addr  in  AW  EX destination register
- ex_data  in  DW  EX ALU result
- mem_valid  in  1  MEM-stage instruction valid
- mem_wen  in  1  MEM instruction writes a register
- mem_addr  in  AW  MEM destination register
- mem_data  in  DW  MEM result (incl. load data)
- wb_we  in  1  regfile write enable this cycle (same signal as regfile we)
- wb_waddr  in  AW  regfile write address
- wb_wdata  in  DW  regfile write data
- flush  in  1  kill ID/EX contents and the current input
- out_valid  out  1  ID/EX register holds valid instruction
- out_ready  in  1  EX accepts
- out_op1  out  DW  resolved operand 1
- out_op2  out  DW  resolved operand 2
- out_rd  out  AW  destination register
- out_wen  out  1  write enable
- out_is_load  out  1  load flag
- out_imm  out  DW  immediate
- out_ctrl  out  CW  control bundle
- stall_count  out  16  saturating count of load-use stall cycles

Behaviour:
- Reset (rst=0 at edge): out_valid=0, all out_* data = 0, stall_count=0. Reset mid-operation discards held contents.
- raddr1=in_rs, raddr2=in_rt, combinational, every cycle regardless of in_valid.
- Operand resolution per source s, combinational, priority order:
  - s==0 -> 0.
  - EX hit (ex_valid & ex_wen & ex_addr==s & !ex_is_load) -> ex_data.
  - MEM hit (mem_valid & mem_wen & mem_addr==s) -> mem_data.
  - WB hit (wb_we & wb_waddr==s) -> wb_wdata.
  - Otherwise rdata.
- hazard = in_valid & ex_valid & ex_wen & ex_is_load & ex_addr!=0 & (ex_addr==in_rs | ex_addr==in_rt).
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Capture: on in_valid & in_ready, ID/EX loads resolved operands and in_* fields; out_valid<=1.
- out_valid & out_ready with no capture -> out_valid<=0; data fields hold their last value.
- out_valid & !out_ready -> all out_* stable.
- flush has priority over capture and hold: out_valid<=0 next cycle; input not consumed.
- Latency: 1 cycle from accepted input to out_valid.
- A hazard inserts exactly one bubble: out_valid drops if EX drains and nothing is captured. The next cycle the load is in MEM and its data bypasses via MEM.
- stall_count increments on each cycle with hazard=1 and flush=0; saturates at 16'hFFFF, no wrap.

Optional Feature:
- Macro: OPSTAGE_WB_BYPASS_EN.
- Defined: WB hit bypass active as above.
- Undefined: WB bypass removed; the regfile must supply write-first read data for the same-cycle address. Resolution is then EX > MEM > rdata.

Test Plan:
- Reset: rst=0 two cycles, in_valid=1 -> out_valid=0, out_op1=out_op2=0, stall_count=0 after release.
- WB bypass: rdata1=0 (stale), wb_we=1, wb_waddr=1, wb_wdata=10, in_rs=in_rt=1, in_valid=1 -> next cycle out_op1=out_op2=10. With macro undefined, out_op1=out_op2=rdata1/rdata2 value.
- Priority: ex_addr=mem_addr=wb_waddr=3, data 0x11/0x22/0x33, in_rs=3 -> out_op1=0x11. Drop ex_valid -> 0x22. Drop mem_valid -> 0x33. in_rs=0 with all hits on addr 0 -> out_op1=0.
- Load-use: ex_is_load=1, ex_addr=5, in_rt=5 -> in_ready=0 one cycle, stall_count=1. Next cycle mem_addr=5, mem_data=0xABCD -> accepted, out_op2=0xABCD.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, out_* unchanged. out_ready=1 -> new instruction captured same edge.
- Flush: flush=1 with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, input not consumed. Counter preset near 16'hFFFF, then hazard held -> saturates at 16'hFFFF.
